div_restoring: RTL and testbench

//  Multi-cycle unsigned restoring divider; inverse of the 5x5 multiplier datapath.

---
 rtl/trachtenberg_pkg.sv | 18 +
 rtl/div_restoring_step.sv | 23 ++
 rtl/div_restoring.sv | 105 ++++++++++
 tb/tb_div_restoring.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/trachtenberg_pkg.sv
// Shared definitions for the multiplier/divider datapath: default widths and
// the state encoding of the multi-cycle divider.
package trachtenberg_pkg;

  localparam int A_W = 10;
  localparam int B_W = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } div_state_t;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits and shift in the quotient bit.
module div_step #(
  parameter int A_W = 10,
  parameter int B_W = 5
) (
  input  logic [B_W:0]   r,
  input  logic [A_W-1:0] q,
  input  logic [B_W-1:0] d,
  output logic [B_W:0]   r_nxt,
  output logic [A_W-1:0] q_nxt
);

  logic [B_W:0] r_sh;
  logic         fits;

  // r stays below d between steps, so the shifted value fits in B_W+1 bits
  assign r_sh  = {r[B_W-1:0], q[A_W-1]};
  assign fits  = (r_sh >= {1'b0, d});
  assign r_nxt = fits ? (r_sh - {1'b0, d}) : r_sh;
  assign q_nxt = {q[A_W-2:0], fits};

endmodule

// File: rtl/div_restoring.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock with an
// istart/oready/ovalid handshake; divide-by-zero is flagged in one cycle.
module div_restoring
  import trachtenberg_pkg::*;
#(
  parameter int A_W = trachtenberg_pkg::A_W,
  parameter int B_W = trachtenberg_pkg::B_W
) (
  input  logic           iclk,
  input  logic           irst_n,
  input  logic [A_W-1:0] ia,
  input  logic [B_W-1:0] ib,
  input  logic           istart,
  output logic [A_W-1:0] oquot,
  output logic [B_W-1:0] orem,
  output logic           ovalid,
  output logic           oready,
  output logic           odiv0
);

  localparam int CNT_W = (A_W > 2) ? $clog2(A_W) : 1;

  div_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [B_W:0]   r;
  logic [A_W-1:0] q;
  logic [B_W-1:0] d;
  logic [B_W:0]   r_nxt;
  logic [A_W-1:0] q_nxt;
  logic           accept;

  assign accept = istart && oready;

  div_step #(.A_W(A_W), .B_W(B_W)) u_step (
    .r     (r),
    .q     (q),
    .d     (d),
    .r_nxt (r_nxt),
    .q_nxt (q_nxt)
  );

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      oquot  <= '0;
      orem   <= '0;
      ovalid <= 1'b0;
      odiv0  <= 1'b0;
      oready <= 1'b1;
    end else begin
      ovalid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (istart) begin
            if (ib != '0) begin
              state  <= S_RUN;
              cnt    <= CNT_W'(A_W - 1);
              oready <= 1'b0;
            end else begin
              state  <= S_DONE;
              oquot  <= '1;
              orem   <= '0;
              odiv0  <= 1'b1;
              ovalid <= 1'b1;
              oready <= 1'b1;
            end
          end else begin
            state  <= S_IDLE;
            oready <= 1'b1;
          end
        end
        S_RUN: begin
          if (cnt == '0) begin
            state  <= S_DONE;
            oquot  <= q_nxt;
            orem   <= r_nxt[B_W-1:0];
            odiv0  <= 1'b0;
            ovalid <= 1'b1;
            oready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          oready <= 1'b1;
        end
      endcase
    end
  end

  // Working registers carry no reset: they are always reloaded on acceptance
  always_ff @(posedge iclk) begin
    if (accept && (ib != '0)) begin
      r <= '0;
      q <= ia;
      d <= ib;
    end else if (state == S_RUN) begin
      r <= r_nxt;
      q <= q_nxt;
    end
  end

endmodule

// File: tb/tb_div_restoring.sv
// Directed and swept checks for the restoring divider.
module tb_div_restoring;

  localparam int A_W = 10;
  localparam int B_W = 5;

  logic           iclk = 1'b0;
  logic           irst_n;
  logic [A_W-1:0] ia;
  logic [B_W-1:0] ib;
  logic           istart;
  logic [A_W-1:0] oquot;
  logic [B_W-1:0] orem;
  logic           ovalid;
  logic           oready;
  logic           odiv0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 iclk = ~iclk;

  div_restoring #(.A_W(A_W), .B_W(B_W)) dut (
    .iclk   (iclk),
    .irst_n (irst_n),
    .ia     (ia),
    .ib     (ib),
    .istart (istart),
    .oquot  (oquot),
    .orem   (orem),
    .ovalid (ovalid),
    .oready (oready),
    .odiv0  (odiv0)
  );

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int d0;
    int busy;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sample at negedges until ovalid, counting cycles with oready low.
  task automatic wait_result(output int busy, output bit got);
    int guard;
    busy  = 0;
    got   = 1'b0;
    guard = 0;
    while (!got && guard < 40) begin
      @(negedge iclk);
      if (ovalid) got = 1'b1;
      else if (!oready) busy++;
      guard++;
    end
  endtask

  // Called at a negedge: present one operation for a single accepting edge.
  task automatic do_op(input int a, input int b, output int busy, output bit got);
    ia     = A_W'(a);
    ib     = B_W'(b);
    istart = 1'b1;
    @(posedge iclk);
    #1 istart = 1'b0;
    wait_result(busy, got);
  endtask

  initial begin
    int  busy;
    bit  got;
    int  vcount;
    int  a_exp;

    vecs[0]  = '{a: 200,  b: 7,  q: 28,   r: 4,  d0: 0, busy: 10};
    vecs[1]  = '{a: 1023, b: 31, q: 33,   r: 0,  d0: 0, busy: 10};
    vecs[2]  = '{a: 0,    b: 1,  q: 0,    r: 0,  d0: 0, busy: 10};
    vecs[3]  = '{a: 5,    b: 0,  q: 1023, r: 0,  d0: 1, busy: 0};
    vecs[4]  = '{a: 9,    b: 4,  q: 2,    r: 1,  d0: 0, busy: 10};
    vecs[5]  = '{a: 1023, b: 1,  q: 1023, r: 0,  d0: 0, busy: 10};
    vecs[6]  = '{a: 1000, b: 31, q: 32,   r: 8,  d0: 0, busy: 10};
    vecs[7]  = '{a: 511,  b: 16, q: 31,   r: 15, d0: 0, busy: 10};
    vecs[8]  = '{a: 1,    b: 31, q: 0,    r: 1,  d0: 0, busy: 10};
    vecs[9]  = '{a: 0,    b: 0,  q: 1023, r: 0,  d0: 1, busy: 0};
    vecs[10] = '{a: 31,   b: 31, q: 1,    r: 0,  d0: 0, busy: 10};

    irst_n = 1'b0;
    istart = 1'b0;
    ia     = '0;
    ib     = '0;
    repeat (2) @(negedge iclk);
    check("reset oquot",  int'(oquot),  0);
    check("reset orem",   int'(orem),   0);
    check("reset ovalid", int'(ovalid), 0);
    check("reset oready", int'(oready), 1);
    check("reset odiv0",  int'(odiv0),  0);
    irst_n = 1'b1;
    @(negedge iclk);

    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].a, vecs[i].b, busy, got);
      check($sformatf("v%0d got ovalid", i), int'(got), 1);
      check($sformatf("v%0d busy cycles", i), busy, vecs[i].busy);
      check($sformatf("v%0d oquot", i), int'(oquot), vecs[i].q);
      check($sformatf("v%0d orem", i),  int'(orem),  vecs[i].r);
      check($sformatf("v%0d odiv0", i), int'(odiv0), vecs[i].d0);
      @(negedge iclk);
      check($sformatf("v%0d ovalid pulse", i), int'(ovalid), 0);
      check($sformatf("v%0d oready after", i), int'(oready), 1);
      check($sformatf("v%0d oquot held", i), int'(oquot), vecs[i].q);
    end

    // istart during RUN is ignored; istart held into DONE is taken back-to-back
    ia = 10'd100; ib = 5'd3; istart = 1'b1;
    @(posedge iclk);
    #1 istart = 1'b0;
    busy = 0; got = 1'b0; vcount = 0;
    while (!got && vcount < 40) begin
      @(negedge iclk);
      vcount++;
      if (ovalid) got = 1'b1;
      else begin
        if (!oready) busy++;
        if (busy == 3 || busy == 8) begin
          ia = 10'd50; ib = 5'd5; istart = 1'b1;
        end else if (busy == 4) begin
          istart = 1'b0;
        end
      end
    end
    check("b2b first got", int'(got), 1);
    check("b2b first busy", busy, 10);
    check("b2b first oquot", int'(oquot), 33);
    check("b2b first orem", int'(orem), 1);
    @(posedge iclk);
    #1 istart = 1'b0;
    wait_result(busy, got);
    check("b2b second got", int'(got), 1);
    check("b2b second busy", busy, 10);
    check("b2b second oquot", int'(oquot), 10);
    check("b2b second orem", int'(orem), 0);
    @(negedge iclk);

    // Asynchronous reset four cycles into RUN
    ia = 10'd200; ib = 5'd7; istart = 1'b1;
    @(posedge iclk);
    #1 istart = 1'b0;
    repeat (4) @(negedge iclk);
    #2 irst_n = 1'b0;
    #1;
    check("abort ovalid", int'(ovalid), 0);
    check("abort oready", int'(oready), 1);
    check("abort oquot",  int'(oquot),  0);
    check("abort orem",   int'(orem),   0);
    @(negedge iclk);
    irst_n = 1'b1;
    vcount = 0;
    repeat (15) begin
      @(negedge iclk);
      if (ovalid) vcount++;
    end
    check("abort no pulse", vcount, 0);

    // Sweep of dividends against every nonzero divisor
    for (int a = 0; a < 1024; a += (a == 1015) ? 8 : 13) begin
      for (int b = 1; b < 32; b++) begin
        do_op(a, b, busy, got);
        n_cmp++;
        if (!got || int'(oquot) != a / b || int'(orem) != a % b ||
            int'(oquot) * b + int'(orem) != a || int'(orem) >= b || odiv0) begin
          n_err++;
          $display("FAIL sweep %0d/%0d: got q=%0d r=%0d, expected q=%0d r=%0d",
                   a, b, oquot, orem, a / b, a % b);
        end
      end
    end

    // Products of 5-bit operands divide back to the original factor
    for (int a = 0; a < 32; a++) begin
      for (int b = 1; b < 32; b++) begin
        a_exp = a;
        do_op(a * b, b, busy, got);
        n_cmp++;
        if (!got || int'(oquot) != a_exp || orem != '0) begin
          n_err++;
          $display("FAIL product (%0d*%0d)/%0d: got q=%0d r=%0d, expected q=%0d r=0",
                   a, b, b, oquot, orem, a_exp);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
